// File: rtl/entity_pos_updater.sv
// Purpose : per-frame sequencer that reads every entity's position/velocity,
//           computes the next position with screen-edge handling and writes it back.
// Latency : 3 cycles per entity; 1 + 3*N_ENT + 1 cycles from START to DONE with GRANT held.
// Backpressure: losing GRANT suppresses the write in that cycle and parks the FSM in WAIT;
//           the current entity is re-read from scratch after re-grant.
// Build option: define POS_WRAP_EN for torus wrap at the screen edges (default is clamp).
module entity_pos_updater #(
    parameter int N_ENT   = 4,
    parameter int ADDR_W  = $clog2(N_ENT),
    parameter int COORD_W = 10,
    parameter int VEL_W   = 4,
    parameter int X_MAX   = 639,
    parameter int Y_MAX   = 479
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               START,
    input  logic               GRANT,
    output logic               REQ,
    output logic [ADDR_W-1:0]  POS_ADDR,
    output logic               POS_WE,
    input  logic [COORD_W-1:0] RD_X,
    input  logic [COORD_W-1:0] RD_Y,
    input  logic [VEL_W-1:0]   RD_VX,
    input  logic [VEL_W-1:0]   RD_VY,
    output logic [COORD_W-1:0] WR_X,
    output logic [COORD_W-1:0] WR_Y,
    output logic               BUSY,
    output logic               DONE,
    output logic               OVERRUN
);

    // Two extra bits: one for the carry past COORD_W, one for the sign.
    localparam int SW = COORD_W + 2;

    localparam logic signed [SW-1:0]  X_LIM_S  = SW'(X_MAX);
    localparam logic signed [SW-1:0]  Y_LIM_S  = SW'(Y_MAX);
    localparam logic [COORD_W-1:0]    X_MAX_C  = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0]    Y_MAX_C  = COORD_W'(Y_MAX);
    localparam logic [COORD_W-1:0]    X_SPAN_C = COORD_W'(X_MAX + 1);
    localparam logic [COORD_W-1:0]    Y_SPAN_C = COORD_W'(Y_MAX + 1);
    localparam logic [ADDR_W-1:0]     LAST_IDX = ADDR_W'(N_ENT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RD,
        S_CALC,
        S_WR,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q,   idx_d;
    logic [COORD_W-1:0]  wr_x_q,  wr_x_d;
    logic [COORD_W-1:0]  wr_y_q,  wr_y_d;
    logic                ovr_q,   ovr_d;

    // Next coordinate for one axis. Velocities are small relative to the
    // screen span, so one correction step always lands back in range; the
    // wrap results therefore fit in COORD_W bits and modular add/sub is exact.
    function automatic logic [COORD_W-1:0] next_coord(
        input logic [COORD_W-1:0]  pos,
        input logic [VEL_W-1:0]    vel,
        input logic signed [SW-1:0] lim_s,
        input logic [COORD_W-1:0]  max_c,
        input logic [COORD_W-1:0]  span_c
    );
        logic signed [SW-1:0] sum;
        logic [COORD_W-1:0]   res;
        sum = $signed({2'b00, pos}) + SW'($signed(vel));
`ifdef POS_WRAP_EN
        if (sum < SW'(0)) begin
            res = sum[COORD_W-1:0] + span_c;
        end else if (sum > lim_s) begin
            res = sum[COORD_W-1:0] - span_c;
        end else begin
            res = sum[COORD_W-1:0];
        end
        // max_c only matters for clamping
        if (max_c == '0) begin
            res = sum[COORD_W-1:0];
        end
`else
        if (sum < SW'(0)) begin
            res = '0;
        end else if (sum > lim_s) begin
            res = max_c;
        end else begin
            res = sum[COORD_W-1:0];
        end
        // span_c only matters for wrapping
        if (span_c == '0) begin
            res = sum[COORD_W-1:0];
        end
`endif
        return res;
    endfunction

    // State, index, write data and sticky overrun register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wr_x_q  <= '0;
            wr_y_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wr_x_q  <= wr_x_d;
            wr_y_q  <= wr_y_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state logic and Moore outputs; GRANT loss in RD/CALC/WR parks in WAIT.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_x_d  = wr_x_q;
        wr_y_d  = wr_y_q;
        // Any START outside IDLE (DONE included) is a frame overrun.
        ovr_d   = ovr_q | (START & (state_q != S_IDLE));

        REQ    = 1'b0;
        POS_WE = 1'b0;
        BUSY   = 1'b0;
        DONE   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_WAIT;
                    idx_d   = '0;
                end
            end
            S_WAIT: begin
                REQ  = 1'b1;
                BUSY = 1'b1;
                if (GRANT) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                REQ  = 1'b1;
                BUSY = 1'b1;
                state_d = GRANT ? S_CALC : S_WAIT;
            end
            S_CALC: begin
                REQ  = 1'b1;
                BUSY = 1'b1;
                if (GRANT) begin
                    wr_x_d  = next_coord(RD_X, RD_VX, X_LIM_S, X_MAX_C, X_SPAN_C);
                    wr_y_d  = next_coord(RD_Y, RD_VY, Y_LIM_S, Y_MAX_C, Y_SPAN_C);
                    state_d = S_WR;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WR: begin
                REQ  = 1'b1;
                BUSY = 1'b1;
                // A reset in this cycle must not let the write through.
                POS_WE = GRANT & ~Reset;
                if (!GRANT) begin
                    state_d = S_WAIT;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                DONE    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The index doubles as the file address, so it naturally holds in IDLE.
    assign POS_ADDR = idx_q;
    assign WR_X     = wr_x_q;
    assign WR_Y     = wr_y_q;
    assign OVERRUN  = ovr_q;

endmodule

// File: tb/tb_entity_pos_updater.sv
// Purpose : directed bench for entity_pos_updater with a synchronous-read entity file model.
// Latency : file model returns read data one cycle after the address.
// Backpressure: GRANT is driven directly by the stimulus to exercise withdrawal.
module tb_entity_pos_updater;

    logic       Clk;
    logic       Reset;
    logic       START;
    logic       GRANT;
    logic       REQ;
    logic [1:0] POS_ADDR;
    logic       POS_WE;
    logic [9:0] RD_X, RD_Y;
    logic [3:0] RD_VX, RD_VY;
    logic [9:0] WR_X, WR_Y;
    logic       BUSY;
    logic       DONE;
    logic       OVERRUN;

    // Expected post-pass values for entities 1 and 3 depend on the edge mode.
`ifdef POS_WRAP_EN
    localparam int E1X = 3;   // 638+5=643 -> 643-640
    localparam int E1Y = 477; // 1-4=-3   -> -3+480
    localparam int E3X = 639; // 0-1=-1   -> -1+640
    localparam int E3Y = 1;   // 479+2    -> 481-480
`else
    localparam int E1X = 639;
    localparam int E1Y = 0;
    localparam int E3X = 0;
    localparam int E3Y = 479;
`endif

    entity_pos_updater dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .START    (START),
        .GRANT    (GRANT),
        .REQ      (REQ),
        .POS_ADDR (POS_ADDR),
        .POS_WE   (POS_WE),
        .RD_X     (RD_X),
        .RD_Y     (RD_Y),
        .RD_VX    (RD_VX),
        .RD_VY    (RD_VY),
        .WR_X     (WR_X),
        .WR_Y     (WR_Y),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .OVERRUN  (OVERRUN)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Entity file model: synchronous read, write on POS_WE, plus a write log.
    logic [9:0] mx [4];
    logic [9:0] my [4];
    logic [3:0] mvx [4];
    logic [3:0] mvy [4];
    logic       load, clr;
    int         wr_cnt;
    logic [7:0] wr_log;

    always @(posedge Clk) begin
        RD_X  <= mx[POS_ADDR];
        RD_Y  <= my[POS_ADDR];
        RD_VX <= mvx[POS_ADDR];
        RD_VY <= mvy[POS_ADDR];
        if (load) begin
            mx[0] <= 10'd10;  my[0] <= 10'd20;  mvx[0] <= 4'd1; mvy[0] <= 4'd1;
            mx[1] <= 10'd638; my[1] <= 10'd1;   mvx[1] <= 4'd5; mvy[1] <= 4'hC;
            mx[2] <= 10'd100; my[2] <= 10'd50;  mvx[2] <= 4'd3; mvy[2] <= 4'hE;
            mx[3] <= 10'd0;   my[3] <= 10'd479; mvx[3] <= 4'hF; mvy[3] <= 4'd2;
        end else if (POS_WE) begin
            mx[POS_ADDR] <= WR_X;
            my[POS_ADDR] <= WR_Y;
        end
        if (clr) begin
            wr_cnt <= 0;
            wr_log <= 8'h00;
        end else if (POS_WE) begin
            wr_cnt <= wr_cnt + 1;
            wr_log <= {wr_log[5:0], POS_ADDR};
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    // Cycles counted from the current one (n=1) up to the DONE cycle, bounded.
    task automatic run_done(output int n);
        n = 1;
        while (DONE !== 1'b1 && n < 60) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        Reset = 1'b1; START = 1'b0; GRANT = 1'b0; load = 1'b1; clr = 1'b1;
        cyc();
        cyc();
        chk("rst_req",  REQ, 0);
        chk("rst_we",   POS_WE, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_ovr",  OVERRUN, 0);
        chk("rst_addr", POS_ADDR, 0);
        chk("rst_wrx",  WR_X, 0);
        chk("rst_wry",  WR_Y, 0);
        Reset = 1'b0; load = 1'b0; clr = 1'b0; GRANT = 1'b1;

        // Basic pass with GRANT already high.
        START = 1'b1; cyc(); START = 1'b0;
        chk("p1_busy", BUSY, 1);
        chk("p1_req",  REQ, 1);
        chk("p1_we",   POS_WE, 0);
        run_done(n);
        chk("p1_done_lat", n, 14);
        cyc();
        chk("p1_done_pulse", DONE, 0);
        chk("p1_idle_busy", BUSY, 0);
        chk("p1_idle_req", REQ, 0);
        chk("p1_addr_hold", POS_ADDR, 3);
        chk("p1_ovr", OVERRUN, 0);
        chk("p1_wr_cnt", wr_cnt, 4);
        chk("p1_wr_order", wr_log, 8'h1B);
        chk("p1_e0x", mx[0], 11);
        chk("p1_e0y", my[0], 21);
        chk("p1_e1x", mx[1], E1X);
        chk("p1_e1y", my[1], E1Y);
        chk("p1_e2x", mx[2], 103);
        chk("p1_e2y", my[2], 48);
        chk("p1_e3x", mx[3], E3X);
        chk("p1_e3y", my[3], E3Y);

        // START coinciding with DONE counts as overrun and is not started.
        load = 1'b1; clr = 1'b1; cyc(); load = 1'b0; clr = 1'b0;
        START = 1'b1; cyc(); START = 1'b0;
        run_done(n);
        START = 1'b1; cyc(); START = 1'b0;
        chk("dn_ovr", OVERRUN, 1);
        chk("dn_not_started", BUSY, 0);
        cyc();
        chk("dn_still_idle", REQ, 0);
        Reset = 1'b1; cyc();
        chk("dn_ovr_cleared", OVERRUN, 0);
        Reset = 1'b0;

        // Grant withdrawn for 3 cycles starting at CALC of entity 1.
        load = 1'b1; clr = 1'b1; cyc(); load = 1'b0; clr = 1'b0;
        START = 1'b1; cyc(); START = 1'b0;
        repeat (5) cyc();
        chk("gw_addr_calc1", POS_ADDR, 1);
        GRANT = 1'b0; #1;
        chk("gw_we_c6", POS_WE, 0);
        chk("gw_req_c6", REQ, 1);
        cyc();
        chk("gw_we_c7", POS_WE, 0);
        chk("gw_req_c7", REQ, 1);
        chk("gw_addr_held", POS_ADDR, 1);
        cyc();
        chk("gw_we_c8", POS_WE, 0);
        chk("gw_wr_cnt_mid", wr_cnt, 1);
        GRANT = 1'b1;
        run_done(n);
        chk("gw_done_lat", n, 11);
        cyc();
        chk("gw_wr_cnt", wr_cnt, 4);
        chk("gw_wr_order", wr_log, 8'h1B);
        chk("gw_e1x", mx[1], E1X);
        chk("gw_e1y", my[1], E1Y);

        // Late grant: 10 cycles waiting with GRANT low.
        load = 1'b1; clr = 1'b1; cyc(); load = 1'b0; clr = 1'b0;
        GRANT = 1'b0;
        START = 1'b1; cyc(); START = 1'b0;
        bad = 0;
        repeat (10) begin
            if (REQ !== 1'b1 || POS_WE !== 1'b0 || BUSY !== 1'b1) bad++;
            cyc();
        end
        chk("lg_wait_bad", bad, 0);
        chk("lg_no_writes", wr_cnt, 0);
        GRANT = 1'b1;
        run_done(n);
        chk("lg_done_lat", n, 14);
        cyc();
        chk("lg_wr_cnt", wr_cnt, 4);
        chk("lg_e2x", mx[2], 103);

        // Overrun: second START five cycles into the pass.
        load = 1'b1; clr = 1'b1; cyc(); load = 1'b0; clr = 1'b0;
        START = 1'b1; cyc(); START = 1'b0;
        repeat (4) cyc();
        START = 1'b1; cyc(); START = 1'b0;
        chk("ov_flag", OVERRUN, 1);
        chk("ov_busy", BUSY, 1);
        run_done(n);
        chk("ov_no_restart", n, 9);
        cyc();
        chk("ov_wr_cnt", wr_cnt, 4);
        chk("ov_wr_order", wr_log, 8'h1B);
        repeat (3) cyc();
        chk("ov_sticky", OVERRUN, 1);

        // Reset during WR of entity 2.
        Reset = 1'b1; load = 1'b1; clr = 1'b1; cyc();
        Reset = 1'b0; load = 1'b0; clr = 1'b0;
        START = 1'b1; cyc(); START = 1'b0;
        repeat (9) cyc();
        chk("rm_addr_wr2", POS_ADDR, 2);
        chk("rm_we_wr2", POS_WE, 1);
        Reset = 1'b1; #1;
        chk("rm_we_in_reset", POS_WE, 0);
        cyc();
        chk("rm_req", REQ, 0);
        chk("rm_busy", BUSY, 0);
        chk("rm_ovr", OVERRUN, 0);
        chk("rm_addr", POS_ADDR, 0);
        chk("rm_wrx", WR_X, 0);
        chk("rm_wry", WR_Y, 0);
        chk("rm_wr_cnt", wr_cnt, 2);
        chk("rm_e2x_untouched", mx[2], 100);
        Reset = 1'b0;
        load = 1'b1; clr = 1'b1; cyc(); load = 1'b0; clr = 1'b0;
        START = 1'b1; cyc(); START = 1'b0;
        run_done(n);
        chk("rm_pass_lat", n, 14);
        cyc();
        chk("rm_wr_cnt_full", wr_cnt, 4);
        chk("rm_wr_order", wr_log, 8'h1B);
        chk("rm_e2x", mx[2], 103);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/entity_pos_updater.md
Name: entity_pos_updater

Overview:
Position subsystem sequencer. Once per frame tick it walks all entities in the entity file, reads each position and velocity, computes the next position with screen-boundary handling, and writes the result back.
- Drives the position-side address and write-enable inputs of the entity-file access mux.
- Requests file access from the system FSM and proceeds only while granted.

Parameters:
N_ENT, 4, number of entities; index width is ADDR_W = clog2(N_ENT) = 2
COORD_W, 10, unsigned X/Y coordinate width
VEL_W, 4, signed two's-complement velocity width
X_MAX, 639, largest legal X coordinate
Y_MAX, 479, largest legal Y coordinate

Ports:
Clk  in  1  system clock; all state changes on rising edge
Reset  in  1  synchronous, active-high reset
START  in  1  one-cycle frame tick (e.g. vsync edge); starts a pass
GRANT  in  1  file access granted (the system FSM's select for the position subsystem)
REQ  out  1  access request to the system FSM
POS_ADDR  out  ADDR_W  entity index presented to the file mux
POS_WE  out  1  write strobe to the file mux
RD_X  in  COORD_W  X read from the file
RD_Y  in  COORD_W  Y read from the file
RD_VX  in  VEL_W  VX read from the file
RD_VY  in  VEL_W  VY read from the file
WR_X  out  COORD_W  X to write
WR_Y  out  COORD_W  Y to write
BUSY  out  1  pass in progress
DONE  out  1  one-cycle pulse when a pass completes
OVERRUN  out  1  sticky flag: START arrived while BUSY

Behaviour:
- Reset (synchronous, Reset=1 at the edge) forces:
  - state IDLE, entity index 0;
  - REQ, POS_WE, BUSY, DONE and OVERRUN all 0;
  - POS_ADDR, WR_X and WR_Y all 0.
- Reset mid-pass aborts the pass immediately. No write occurs in the reset cycle.
- The entity file has a synchronous read: data for POS_ADDR is valid on RD_* one cycle after the address is presented.
- States: IDLE, WAIT, RD, CALC, WR, DONE.
- IDLE:
  - START=1 -> WAIT, with index cleared to 0 and BUSY=1.
- WAIT:
  - REQ=1.
  - GRANT=1 -> RD.
- RD:
  - POS_ADDR = index, POS_WE=0.
  - Next state CALC.
- CALC:
  - RD_* are valid in this cycle.
  - Register WR_X and WR_Y from the boundary rule below.
  - Next state WR.
- WR:
  - POS_ADDR = index, POS_WE=1 for exactly this cycle.
  - If index == N_ENT-1 -> DONE; otherwise increment index and go to RD.
- DONE:
  - DONE=1 for one cycle; BUSY falls with it.
  - Next state IDLE.
- REQ is held at 1 from WAIT through WR.
- Timing: 3 cycles per entity. A pass takes 1 + 3*N_ENT + 1 cycles after START when GRANT is already high (14 cycles for N_ENT=4).
- GRANT lost during RD, CALC or WR:
  - POS_WE is forced to 0 in that same cycle.
  - The FSM returns to WAIT with the index held.
  - After re-grant it restarts at RD for that entity, so no partial write ever happens.
- START while BUSY is ignored and sets OVERRUN=1. OVERRUN clears only on Reset.
- START in the same cycle as DONE counts as while BUSY and sets OVERRUN.
- Arithmetic:
  - sum = zero-extended RD_X + sign-extended RD_VX, evaluated as a COORD_W+2-bit signed value. Y is handled the same way against Y_MAX.
  - Default (clamp): sum < 0 -> 0; sum > X_MAX -> X_MAX; otherwise sum.
  - Legal VEL_W magnitudes are much smaller than X_MAX, so a single correction always suffices.
- POS_ADDR holds its last value in IDLE.

Optional Feature:
- Macro: POS_WRAP_EN.
- Defined (torus wrap):
  - sum < 0 -> sum + (X_MAX+1);
  - sum > X_MAX -> sum - (X_MAX+1).
  - Y is wrapped the same way using Y_MAX.
- Undefined: clamp as above.
- No other behaviour changes.

Test Plan:
- Basic pass: GRANT=1; entity 2 has X=100, Y=50, VX=+3, VY=-2. Pulse START -> POS_WE pulses 4 times at indices 0,1,2,3; entity 2 writes X=103, Y=48; DONE pulses 14 cycles after START.
- Clamp: X=638, VX=+5 -> WR_X=639; Y=1, VY=-4 -> WR_Y=0. With POS_WRAP_EN: WR_X=3 and WR_Y=477.
- Grant withdrawal: drop GRANT for 3 cycles during CALC of index 1 -> POS_WE=0 throughout, REQ stays 1; after re-grant, index 1 is re-read and written once; the total number of writes is 4.
- Late grant: START with GRANT=0 for 10 cycles -> REQ=1, POS_WE=0 and BUSY=1 while waiting; the pass completes normally once GRANT rises.
- Overrun: START again 5 cycles into a pass -> OVERRUN=1, the pass is not restarted, exactly 4 writes occur; OVERRUN stays 1 until Reset.
- Reset mid-pass: assert Reset during WR of index 2 -> no write in that cycle; all outputs return to 0 on the next edge; a new START then runs a full pass beginning at index 0.
